// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: arbitrates branch/jump resolutions into a FIFO feeding the BTB write port and sequences BTB flushes.
module btb_update_ctrl #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req0_valid_i,
  output logic                      req0_ready_o,
  input  logic                      req0_del_i,
  input  logic [XLEN-1:0]           req0_pc_i,
  input  logic [XLEN-1:0]           req0_target_i,
  input  logic                      req1_valid_i,
  output logic                      req1_ready_o,
  input  logic                      req1_del_i,
  input  logic [XLEN-1:0]           req1_pc_i,
  input  logic [XLEN-1:0]           req1_target_i,
  input  logic                      flush_req_i,
  output logic                      flush_ack_o,
  output logic                      btb_valid_o,
  output logic                      btb_del_entry_o,
  output logic [XLEN-1:0]           btb_res_pc_o,
  output logic [XLEN-1:0]           btb_res_target_o,
  output logic                      btb_flush_o,
  output logic [$clog2(QDEPTH):0]   pending_o
);
  localparam int AW = $clog2(QDEPTH);
  typedef enum logic [1:0] {IDLE, FLUSH, ACK} state_t;
  state_t state, state_nx;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic rr;
  logic q_del [QDEPTH];
  logic [XLEN-1:0] q_pc [QDEPTH];
  logic [XLEN-1:0] q_tgt [QDEPTH];
  logic idle, can, pop, both;
  logic in_del;
  logic [XLEN-1:0] in_pc, in_tgt;
  always_comb begin
    state_nx = state == IDLE ? (flush_req_i ? FLUSH : IDLE) : state == FLUSH ? ACK : IDLE;
    idle = state == IDLE;
    can = idle & ~flush_req_i & (count != (AW+1)'(QDEPTH));
    pop = idle & ~flush_req_i & (count != '0);
    both = req0_valid_i & req1_valid_i;
    // rr=0 favours req0 on contention, rr=1 favours req1
    req0_ready_o = can & req0_valid_i & (~req1_valid_i | ~rr);
    req1_ready_o = can & req1_valid_i & (~req0_valid_i | rr);
    in_del = req1_ready_o ? req1_del_i : req0_del_i;
    in_pc = req1_ready_o ? req1_pc_i : req0_pc_i;
    in_tgt = req1_ready_o ? req1_target_i : req0_target_i;
    btb_valid_o = pop;
    btb_del_entry_o = pop & q_del[rptr];
    btb_res_pc_o = pop ? q_pc[rptr] : '0;
    btb_res_target_o = pop ? q_tgt[rptr] : '0;
    btb_flush_o = state == FLUSH;
    flush_ack_o = state == ACK;
    pending_o = count;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
      rr <= 1'b0;
    end else begin
      state <= state_nx;
      if (idle & flush_req_i) begin
        count <= '0;
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (req0_ready_o | req1_ready_o) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        count <= count + (AW+1)'(req0_ready_o | req1_ready_o) - (AW+1)'(pop);
      end
      if (can & both) rr <= ~rr;
    end
  end
  always_ff @(posedge clk_i) begin
    if (req0_ready_o | req1_ready_o) begin
      q_del[wptr] <= in_del;
      q_pc[wptr] <= in_pc;
      q_tgt[wptr] <= in_tgt;
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: queue-based reference model checked every cycle, plus literal pins on key scenarios.
module tb_btb_update_ctrl;
  localparam int XLEN = 32;
  localparam int QDEPTH = 4;
  typedef struct {logic del; logic [XLEN-1:0] pc; logic [XLEN-1:0] tgt;} ent_t;
  logic clk = 0;
  logic rst, v0, v1, d0, d1, flush;
  logic [XLEN-1:0] pc0, pc1, t0, t1;
  logic r0, r1, ack, bv, bdel, bfl;
  logic [XLEN-1:0] bpc, btgt;
  logic [$clog2(QDEPTH):0] pend;
  int checks = 0, errors = 0;
  ent_t mq[$];
  int phase = 0;
  int mrr = 0;
  bit live = 0;
  logic e_r0, e_r1, e_bv, e_del, e_fl, e_ack;
  logic [XLEN-1:0] e_pc, e_tgt;
  int e_pend;
  always #5 clk = ~clk;
  btb_update_ctrl #(.XLEN(XLEN), .QDEPTH(QDEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_del_i(d0), .req0_pc_i(pc0), .req0_target_i(t0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_del_i(d1), .req1_pc_i(pc1), .req1_target_i(t1),
    .flush_req_i(flush), .flush_ack_o(ack),
    .btb_valid_o(bv), .btb_del_entry_o(bdel), .btb_res_pc_o(bpc), .btb_res_target_o(btgt),
    .btb_flush_o(bfl), .pending_o(pend));
  task automatic cmp(input string n, input logic [XLEN-1:0] a, input logic [XLEN-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic calc();
    bit idle, can;
    idle = phase == 0;
    can = idle && !flush && mq.size() < QDEPTH;
    e_r0 = can && v0 && (!v1 || mrr == 0);
    e_r1 = can && v1 && (!v0 || mrr == 1);
    e_bv = idle && !flush && mq.size() > 0;
    e_del = e_bv ? mq[0].del : 1'b0;
    e_pc = e_bv ? mq[0].pc : '0;
    e_tgt = e_bv ? mq[0].tgt : '0;
    e_fl = phase == 1;
    e_ack = phase == 2;
    e_pend = mq.size();
  endtask
  task automatic sample();
    @(negedge clk);
    if (live) begin
      calc();
      cmp("ready0", r0, e_r0);
      cmp("ready1", r1, e_r1);
      cmp("btb_valid", bv, e_bv);
      cmp("btb_del", bdel, e_del);
      cmp("btb_pc", bpc, e_pc);
      cmp("btb_tgt", btgt, e_tgt);
      cmp("btb_flush", bfl, e_fl);
      cmp("flush_ack", ack, e_ack);
      cmp("pending", pend, e_pend);
    end
  endtask
  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      phase = 0;
      mrr = 0;
      live = 1;
    end else begin
      calc();
      if (e_bv) void'(mq.pop_front());
      if (e_r0) begin e.del = d0; e.pc = pc0; e.tgt = t0; mq.push_back(e); end
      if (e_r1) begin e.del = d1; e.pc = pc1; e.tgt = t1; mq.push_back(e); end
      if (phase == 0 && !flush && mq.size() <= QDEPTH && v0 && v1 && (e_r0 || e_r1)) mrr = 1 - mrr;
      if (phase == 0 && flush) begin mq.delete(); phase = 1; end
      else if (phase == 1) phase = 2;
      else if (phase == 2) phase = 0;
    end
    #1;
  endtask
  task automatic cycle();
    sample();
    tick();
  endtask
  task automatic do_reset();
    rst = 1; v0 = 0; v1 = 0; flush = 0;
    cycle();
    rst = 0;
  endtask
  initial begin
    logic [XLEN-1:0] exp_pc [4];
    exp_pc[0] = 32'hA00; exp_pc[1] = 32'hB01; exp_pc[2] = 32'hA02; exp_pc[3] = 32'hB03;
    rst = 1; v0 = 0; v1 = 0; d0 = 0; d1 = 0; flush = 0;
    pc0 = 0; pc1 = 0; t0 = 0; t1 = 0;
    cycle();
    do_reset();
    sample();
    cmp("rst_pending", pend, 0);
    cmp("rst_valid", bv, 0);
    cmp("rst_ack", ack, 0);
    tick();
    // single push, one-cycle latency
    v0 = 1; pc0 = 32'h100; t0 = 32'h200;
    sample(); cmp("single_ready", r0, 1); tick();
    v0 = 0;
    sample();
    cmp("single_bv", bv, 1); cmp("single_pc", bpc, 32'h100);
    cmp("single_tgt", btgt, 32'h200); cmp("single_pend1", pend, 1);
    tick();
    sample(); cmp("single_pend0", pend, 0); cmp("single_bv0", bv, 0); tick();
    // contention alternates starting with req0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v0 = 1; v1 = 1; pc0 = 32'hA00 + i; pc1 = 32'hB00 + i; t0 = i; t1 = i; d0 = 0; d1 = 1;
      sample();
      cmp("rr_ready0", r0, (i % 2) == 0);
      cmp("rr_ready1", r1, (i % 2) == 1);
      if (i > 0) cmp("rr_order", bpc, exp_pc[i-1]);
      tick();
    end
    v0 = 0; v1 = 0;
    sample(); cmp("rr_order_last", bpc, exp_pc[3]); cmp("rr_del_last", bdel, 1); tick();
    // flush with an entry pending: entry dropped
    v0 = 1; pc0 = 32'h300; t0 = 32'h400; d0 = 0;
    cycle();
    v0 = 0; flush = 1;
    sample(); cmp("fl_bv", bv, 0); cmp("fl_pend", pend, 1); tick();
    flush = 0;
    sample(); cmp("fl_flush", bfl, 1); cmp("fl_pend0", pend, 0); cmp("fl_bv2", bv, 0); tick();
    sample(); cmp("fl_ack", ack, 1); cmp("fl_flush0", bfl, 0); tick();
    sample(); cmp("fl_ack0", ack, 0); cmp("fl_bv3", bv, 0); tick();
    // flush and request together: request waits for return to IDLE
    flush = 1; v0 = 1; pc0 = 32'h500; t0 = 32'h600;
    sample(); cmp("sim_r0_idle", r0, 0); tick();
    flush = 0;
    sample(); cmp("sim_r0_flush", r0, 0); tick();
    sample(); cmp("sim_r0_ack", r0, 0); tick();
    sample(); cmp("sim_r0_after", r0, 1); tick();
    v0 = 0;
    sample(); cmp("sim_pc", bpc, 32'h500); tick();
    // reset during FLUSH: no ack pulse
    flush = 1; cycle();
    flush = 0;
    sample(); cmp("rf_flush", bfl, 1);
    rst = 1; tick();
    rst = 0; v0 = 1; pc0 = 32'h700;
    sample(); cmp("rf_ack", ack, 0); cmp("rf_pend", pend, 0); cmp("rf_ready", r0, 1); tick();
    v0 = 0; cycle();
    // mixed traffic, model-checked each cycle
    for (int i = 0; i < 60; i++) begin
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      d0 = 1'($urandom_range(0, 1)); d1 = 1'($urandom_range(0, 1));
      pc0 = $urandom; pc1 = $urandom; t0 = $urandom; t1 = $urandom;
      flush = $urandom_range(0, 9) == 0;
      cycle();
    end
    v0 = 0; v1 = 0; flush = 0;
    cycle(); cycle(); cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
